// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: receive-only PS/2 mouse decoder turning stream-mode packets into paddle speed/direction.
module ps2_mouse_rx #(
  parameter int FILTER_LEN      = 4,
  parameter int TIMEOUT_CYCLES  = 2500,
  parameter int NEW_DATA_CYCLES = 2
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] paddle0_speed,
  output logic       paddle0_dir,
  output logic       new_data,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NW = $clog2(NEW_DATA_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t        state_q, state_d;
  logic [1:0]    clk_s_q, clk_s_d, dat_s_q, dat_s_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] to_q, to_d;
  logic [1:0]    idx_q, idx_d;
  logic          sign_q, sign_d, ovf_q, ovf_d;
  logic [7:0]    speed_q, speed_d;
  logic          dir_q, dir_d;
  logic [NW-1:0] nd_cnt_q, nd_cnt_d;
  logic          nd_q, nd_d, err_q, err_d;
  logic          sclk, sdat, flip, fall, timeout, done;
  always_comb begin
    clk_s_d  = {clk_s_q[0], ps2_clk};
    dat_s_d  = {dat_s_q[0], ps2_data};
    sclk     = clk_s_q[1];
    sdat     = dat_s_q[1];
    flip     = (sclk != filt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
    fcnt_d   = (sclk == filt_q || flip) ? '0 : fcnt_q + 1'b1;
    filt_d   = flip ? sclk : filt_q;
    fall     = flip & filt_q;
    timeout  = (state_q != IDLE) && !fall && (to_q == TW'(TIMEOUT_CYCLES - 1));
    to_d     = (state_q == IDLE || fall) ? '0 : to_q + 1'b1;
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_ok_d = par_ok_q;
    idx_d    = idx_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    speed_d  = speed_q;
    dir_d    = dir_q;
    err_d    = 1'b0;
    done     = 1'b0;
    nd_cnt_d = (nd_cnt_q != '0) ? nd_cnt_q - 1'b1 : '0;
    nd_d     = nd_cnt_q != '0;
    if (timeout) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      err_d   = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: if (!sdat) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
        DATA: begin
          shift_d = {sdat, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_ok_d = ^{shift_q, sdat};
          state_d  = STOP;
        end
        default: begin
          state_d = IDLE;
          done    = sdat && par_ok_q;
          err_d   = !(sdat && par_ok_q);
          idx_d   = (sdat && par_ok_q) ? idx_q : 2'd0;
        end
      endcase
    end
    // Byte 0 without bit3 is a misaligned stream: drop it quietly and keep looking for a header.
    if (done) begin
      if (idx_q == 2'd0) begin
        idx_d  = shift_q[3] ? 2'd1 : 2'd0;
        sign_d = shift_q[3] ? shift_q[5] : sign_q;
        ovf_d  = shift_q[3] ? shift_q[7] : ovf_q;
      end else if (idx_q == 2'd1) begin
        idx_d = 2'd2;
      end else begin
        idx_d    = 2'd0;
        dir_d    = ~sign_q;
        speed_d  = (ovf_q || (sign_q && shift_q == 8'd0)) ? 8'hFF : sign_q ? 8'(-shift_q) : shift_q;
        nd_cnt_d = NW'(NEW_DATA_CYCLES);
      end
    end
  end
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      clk_s_q  <= 2'b11;
      dat_s_q  <= 2'b11;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= IDLE;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      par_ok_q <= 1'b0;
      to_q     <= '0;
      idx_q    <= 2'd0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      speed_q  <= 8'd0;
      dir_q    <= 1'b1;
      nd_cnt_q <= '0;
      nd_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      clk_s_q  <= clk_s_d;
      dat_s_q  <= dat_s_d;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_ok_q <= par_ok_d;
      to_q     <= to_d;
      idx_q    <= idx_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      speed_q  <= speed_d;
      dir_q    <= dir_d;
      nd_cnt_q <= nd_cnt_d;
      nd_q     <= nd_d;
      err_q    <= err_d;
    end
  end
  assign paddle0_speed = speed_q;
  assign paddle0_dir   = dir_q;
  assign new_data      = nd_q;
  assign frame_err     = err_q;
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb_ps2_mouse_rx: directed and randomized PS/2 packets checked against an arithmetic model of the Y decode.
module tb_ps2_mouse_rx;
  localparam int H = 25;
  logic       clk = 0, reset = 1, ps2_clk = 1, ps2_data = 1;
  logic [7:0] speed;
  logic       dir, nd, fe;
  int compared = 0, mismatched = 0;
  int cyc = 0, fe_cnt = 0, fe_w = 0, fe_run = 0, fe_cyc = 0;
  int nd_rises = 0, nd_w = 0, nd_run = 0, t_fall = 0, nd0 = 0, fe0 = 0;
  logic       nd_prev = 0, fe_prev = 0, dir_pre = 1, dir_last = 1;
  logic [7:0] spd_pre = 0, spd_last = 0, spd0;
  always #20 clk = ~clk;
  ps2_mouse_rx dut (
    .clk_25MHz(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .paddle0_speed(speed), .paddle0_dir(dir), .new_data(nd), .frame_err(fe)
  );
  always @(negedge clk) begin
    cyc++;
    if (nd && !nd_prev) begin
      nd_rises++;
      spd_pre = spd_last;
      dir_pre = dir_last;
    end
    nd_run = nd ? nd_run + 1 : 0;
    if (nd) nd_w = nd_run;
    if (fe && !fe_prev) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    fe_run = fe ? fe_run + 1 : 0;
    if (fe) fe_w = fe_run;
    nd_prev  = nd;
    fe_prev  = fe;
    spd_last = speed;
    dir_last = dir;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // Y is a 9-bit signed count: sign from the header byte, low 8 bits from byte 2.
  function automatic void model(input logic [7:0] b0, input logic [7:0] b2,
                                output logic [7:0] s, output logic d);
    int y, m;
    y = b0[5] ? int'(b2) - 256 : int'(b2);
    m = (y < 0) ? -y : y;
    d = (y >= 0);
    s = (b0[7] || m > 255) ? 8'hFF : 8'(m);
  endfunction
  task automatic send_bit(input logic b, input bit glitch);
    @(negedge clk) ps2_data = b;
    repeat (H / 2) @(negedge clk);
    if (glitch) begin
      ps2_clk = 0;
      repeat (2) @(negedge clk);
      ps2_clk = 1;
    end
    repeat (H / 2) @(negedge clk);
    ps2_clk = 0;
    t_fall  = cyc;
    repeat (H) @(negedge clk);
    ps2_clk = 1;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit bad_par = 0, input int gbit = -1);
    send_bit(1'b0, gbit == 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], gbit == i + 1);
    send_bit(~^b ^ bad_par, gbit == 9);
    send_bit(1'b1, gbit == 10);
    repeat (4 * H) @(negedge clk);
  endtask
  task automatic snap();
    nd0  = nd_rises;
    fe0  = fe_cnt;
    spd0 = speed;
  endtask
  task automatic pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2, input int gbit = -1);
    logic [7:0] es;
    logic       ed;
    model(b0, b2, es, ed);
    snap();
    send_byte(b0);
    send_byte(b1);
    send_byte(b2, 0, gbit);
    repeat (10) @(negedge clk);
    chk({tag, " new_data count"}, nd_rises - nd0, 1);
    chk({tag, " speed"}, speed, es);
    chk({tag, " dir"}, dir, ed);
    chk({tag, " speed before new_data"}, spd_pre, es);
    chk({tag, " dir before new_data"}, dir_pre, ed);
    chk({tag, " new_data width"}, nd_w, 2);
    chk({tag, " no frame_err"}, fe_cnt - fe0, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset speed", speed, 0);
    chk("reset dir", dir, 1);
    chk("reset new_data", nd, 0);
    chk("reset frame_err", fe, 0);
    reset = 0;
    repeat (20) @(negedge clk);
    pkt("pkt 08 00 05", 8'h08, 8'h00, 8'h05);
    pkt("pkt 28 00 FB", 8'h28, 8'h00, 8'hFB);
    pkt("pkt 28 00 00", 8'h28, 8'h00, 8'h00);
    pkt("pkt 88 00 10", 8'h88, 8'h00, 8'h10);
    snap();
    send_byte(8'h08);
    send_byte(8'h00, 1);
    repeat (10) @(negedge clk);
    chk("parity err pulse", fe_cnt - fe0, 1);
    chk("parity err width", fe_w, 1);
    chk("parity err timing", (fe_cyc - t_fall >= 4) && (fe_cyc - t_fall <= 10), 1);
    chk("parity err no new_data", nd_rises - nd0, 0);
    chk("parity err speed kept", speed, spd0);
    pkt("after parity 08 00 03", 8'h08, 8'h00, 8'h03);
    snap();
    send_byte(8'h00);
    chk("misaligned drop no frame_err", fe_cnt - fe0, 0);
    chk("misaligned drop no new_data", nd_rises - nd0, 0);
    pkt("aligned 08 00 07", 8'h08, 8'h00, 8'h07);
    snap();
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    repeat (3000) @(negedge clk);
    chk("timeout pulse", fe_cnt - fe0, 1);
    chk("timeout width", fe_w, 1);
    chk("timeout timing", (fe_cyc - t_fall >= 2500) && (fe_cyc - t_fall <= 2515), 1);
    chk("timeout no new_data", nd_rises - nd0, 0);
    pkt("after timeout 08 00 2A", 8'h08, 8'h00, 8'h2A);
    pkt("glitch 28 00 F0", 8'h28, 8'h00, 8'hF0, 4);
    snap();
    send_byte(8'h08);
    send_byte(8'h00);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    #7 reset = 1;
    #1;
    chk("async reset speed", speed, 0);
    chk("async reset dir", dir, 1);
    chk("async reset new_data", nd, 0);
    chk("async reset frame_err", fe, 0);
    repeat (5) @(negedge clk);
    reset = 0;
    repeat (20) @(negedge clk);
    chk("reset mid-frame no new_data", nd_rises - nd0, 0);
    pkt("after reset 08 00 0C", 8'h08, 8'h00, 8'h0C);
    for (int k = 0; k < 6; k++) begin
      logic [7:0] b0, b1, b2;
      b0 = 8'($urandom) | 8'h08;
      b1 = 8'($urandom);
      b2 = (k == 5) ? 8'h00 : 8'($urandom);
      pkt($sformatf("random %02x %02x %02x", b0, b1, b2), b0, b1, b2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
